mux4_rr_arbiter: RTL and testbench
==================================

Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared 4:1 mux datapath.
- Four requesters compete for the mux output. The block issues a one-hot grant and drives the 2-bit select (sel[1] = a, sel[0] = b; sel 0..3 selects inputs A..D).
- A configurable hold limit bounds how long any one owner keeps the mux while others wait.
- Sits directly in front of the mux select inputs.

Parameters:
- MAX_HOLD, 4: maximum consecutive grant cycles while another requester is pending. Legal range 1..255.
- CNT_W, 8: width of the internal hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request per requester; bit i = mux input i (A=0, B=1, C=2, D=3).
- grant  output  4  registered one-hot grant; 0000 when idle.
- sel  output  2  registered mux select; drives a (sel[1]) and b (sel[0]).
- busy  output  1  high while any grant is active.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values, applied immediately on rst_n=0 regardless of clock:
  - grant=0000, sel=00, busy=0
  - hold_cnt=0, last_ptr=3 (so requester 0 wins first), state=IDLE
- All outputs are registered. There is no combinational path from req to any output.
- Latency: a request sampled at edge N produces a grant after edge N (visible in cycle N+1).
- Round-robin search starts at (last_ptr+1) mod 4 and scans upward with wrap. The first asserted req wins. last_ptr is updated to the winner on every new grant.
- State IDLE:
  - req==0000: stay in IDLE; grant=0000, busy=0; sel holds its previous value.
  - Any req set: grant the winner, sel=winner index, busy=1, hold_cnt=1, go to GRANT.
- State GRANT, owner i:
  - req[i]=0 and other requests pending: switch directly to the next winner (search from i+1). No idle cycle. hold_cnt=1.
  - req[i]=0 and no other request: grant=0000, busy=0, go to IDLE.
  - req[i]=1, hold_cnt==MAX_HOLD, another request pending: rotate to the next winner. hold_cnt=1.
  - req[i]=1, no other request pending: keep the grant. hold_cnt saturates at MAX_HOLD.
  - Otherwise: keep the grant, hold_cnt+1.
- MAX_HOLD=1: under contention the grant rotates every cycle.
- grant is always one-hot or zero. sel always equals the index of the set grant bit while busy=1.
- Requests that arrive while another requester is granted wait their turn. No request is lost as long as it stays asserted. Requesters must hold req until they are granted.
- Reset asserted mid-grant drops the grant immediately. After release, arbitration restarts from the reset pointer.

Optional Feature:
- MUX_ARB_STATS_EN defined:
  - Adds output port grant_cnt [7:0], reset value 0.
  - Increments by 1 on every new grant: from IDLE, on a switch, or on a rotation. Continuing grants do not count.
  - Wraps from 255 to 0.
- Not defined: the port and counter are absent. All other behaviour is identical.

Test Plan (MAX_HOLD=4):
1. Reset: hold rst_n=0 for 3 cycles with req=1111 -> grant=0000, sel=00, busy=0 throughout, with no clock dependence. First cycle after release -> grant=0001, sel=00.
2. Single requester: req=0100 from cycle 0, held for 10 cycles -> grant=0100, sel=10, busy=1 from cycle 1. No rotation after 4 cycles.
3. Full contention: req=1111 held -> grant sequence 0001 x4, 0010 x4, 0100 x4, 1000 x4, then 0001 again. sel tracks 00, 01, 10, 11.
4. Release handoff: owner 0 granted, req=1001, then req[0] drops -> next cycle grant=1000, sel=11, busy stays 1 (no gap). When req[3] drops with req=0000 -> grant=0000, busy=0, sel stays 11.
5. Reset mid-operation: assert rst_n=0 while grant=0100 -> grant=0000 asynchronously. Release with req=0110 -> grant=0010 (pointer was reset, so requester 0 is searched first; the first pending request found is 1).
6. MUX_ARB_STATS_EN: three grant starts -> grant_cnt=3. Force 256 grant starts from reset -> grant_cnt=0 (wrap).

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the select lines of a shared 4:1 mux, with a hold limit under contention.
// Optional grant-start counter port grant_cnt is enabled by defining MUX_ARB_STATS_EN.
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       busy
`ifdef MUX_ARB_STATS_EN
  ,
  output logic [7:0] grant_cnt
`endif
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [3:0]       grant_nxt;
  logic [1:0]       sel_nxt;
  logic             busy_nxt;
  logic [CNT_W-1:0] hold_cnt, hold_nxt;
  logic [1:0]       last_ptr, ptr_nxt;
  logic [1:0]       win;
  logic             win_found;
  logic             owner_req;
  logic             others;
  logic             new_grant;

  // last_ptr always names the current owner, so one search from last_ptr+1 serves both idle and handoff.
  always_comb begin
    win       = 2'd0;
    win_found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      logic [1:0] idx;
      idx = last_ptr + 2'(k);
      if (!win_found && req[idx]) begin
        win       = idx;
        win_found = 1'b1;
      end
    end
  end

  assign owner_req = |(req & grant);
  assign others    = |(req & ~grant);

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    sel_nxt   = sel;
    busy_nxt  = busy;
    hold_nxt  = hold_cnt;
    ptr_nxt   = last_ptr;
    new_grant = 1'b0;
    case (state)
      IDLE: begin
        if (win_found) new_grant = 1'b1;
      end
      GRANT: begin
        if (!owner_req) begin
          if (others) begin
            new_grant = 1'b1;
          end else begin
            state_nxt = IDLE;
            grant_nxt = 4'b0000;
            busy_nxt  = 1'b0;
            hold_nxt  = '0;
          end
        end else if (!others) begin
          if (hold_cnt < CNT_W'(MAX_HOLD)) hold_nxt = hold_cnt + CNT_W'(1);
        end else if (hold_cnt >= CNT_W'(MAX_HOLD)) begin
          new_grant = 1'b1;
        end else begin
          hold_nxt = hold_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (new_grant) begin
      state_nxt = GRANT;
      grant_nxt = 4'b0001 << win;
      sel_nxt   = win;
      busy_nxt  = 1'b1;
      hold_nxt  = CNT_W'(1);
      ptr_nxt   = win;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= 4'b0000;
      sel      <= 2'b00;
      busy     <= 1'b0;
      hold_cnt <= '0;
      last_ptr <= 2'd3;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      sel      <= sel_nxt;
      busy     <= busy_nxt;
      hold_cnt <= hold_nxt;
      last_ptr <= ptr_nxt;
    end
  end

`ifdef MUX_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         grant_cnt <= 8'd0;
    else if (new_grant) grant_cnt <= grant_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter (MAX_HOLD=4); covers grant_cnt when MUX_ARB_STATS_EN is defined.
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       busy;
`ifdef MUX_ARB_STATS_EN
  logic [7:0] grant_cnt;
`endif

  int total = 0;
  int bad   = 0;

  mux4_rr_arbiter #(.MAX_HOLD(4), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .grant (grant),
    .sel   (sel),
    .busy  (busy)
`ifdef MUX_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] s, input logic b);
    check({tag, ".grant"}, 8'(grant), 8'(g));
    check({tag, ".sel"},   8'(sel),   8'(s));
    check({tag, ".busy"},  8'(busy),  8'(b));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] exp_g;
    rst_n = 1'b0;
    req   = 4'b1111;

    // 1: reset holds outputs low even before any clock edge
    #1;
    chk_out("rst_noclk", 4'b0000, 2'b00, 1'b0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk_out("rst_held", 4'b0000, 2'b00, 1'b0);
    end
    rst_n = 1'b1;

    // 3: full contention rotates every 4 cycles starting at requester 0
    for (int c = 0; c < 17; c++) begin
      step();
      exp_g = 4'b0001 << ((c / 4) % 4);
      chk_out($sformatf("contend%0d", c), exp_g, 2'((c / 4) % 4), 1'b1);
    end

    // 2: lone requester keeps the grant indefinitely
    req = 4'b0100;
    do_reset();
    chk_out("rst_async2", 4'b0000, 2'b00, 1'b0);
    for (int c = 0; c < 10; c++) begin
      step();
      chk_out($sformatf("single%0d", c), 4'b0100, 2'b10, 1'b1);
    end

    // 4: release handoff without a gap, then idle keeps sel
    req = 4'b1001;
    do_reset();
    step();
    chk_out("hand_own0", 4'b0001, 2'b00, 1'b1);
    req = 4'b1000;
    step();
    chk_out("hand_to3", 4'b1000, 2'b11, 1'b1);
    req = 4'b0000;
    step();
    chk_out("hand_idle", 4'b0000, 2'b11, 1'b0);
    step();
    chk_out("hand_idle2", 4'b0000, 2'b11, 1'b0);

    // late arrival waits for owner's hold limit
    req = 4'b0001;
    step();
    chk_out("late_own0", 4'b0001, 2'b00, 1'b1);
    req = 4'b0101;
    step();
    chk_out("late_wait", 4'b0001, 2'b00, 1'b1);
    step();
    step();
    chk_out("late_wait2", 4'b0001, 2'b00, 1'b1);
    step();
    chk_out("late_rot", 4'b0100, 2'b10, 1'b1);

    // 5: reset mid-grant, pointer restarts at requester 0
    req = 4'b0100;
    do_reset();
    step();
    chk_out("mid_own2", 4'b0100, 2'b10, 1'b1);
    rst_n = 1'b0;
    #2;
    chk_out("mid_rst", 4'b0000, 2'b00, 1'b0);
    req = 4'b0110;
    rst_n = 1'b1;
    step();
    chk_out("mid_after", 4'b0010, 2'b01, 1'b1);

`ifdef MUX_ARB_STATS_EN
    req = 4'b0000;
    do_reset();
    check("cnt_rst", grant_cnt, 8'd0);
    req = 4'b0001; step();
    req = 4'b0001; step();
    req = 4'b0000; step();
    req = 4'b0010; step();
    req = 4'b0110; step();
    req = 4'b0100; step();
    check("cnt_three", grant_cnt, 8'd3);
    req = 4'b0000;
    do_reset();
    for (int i = 0; i < 256; i++) begin
      req = 4'b0001; step();
      req = 4'b0000; step();
      if (i == 254) check("cnt_255", grant_cnt, 8'd255);
    end
    check("cnt_wrap", grant_cnt, 8'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
